// File: rtl/chia_xung_tocdo.sv
// Selectable-rate pulse generator: two debounced push-buttons step a power-of-two
// divider level, producing a one-cycle tick and a 50% square wave clk_hz.
module chia_xung_tocdo #(
    parameter int BASE_DIV = 50_000_000,
    parameter int DEB_CYC  = 500_000,
    parameter int NUM_LVL  = 4
) (
    input  logic                       CLK,
    input  logic                       rs,
    input  logic                       btn_up,
    input  logic                       btn_dn,
    output logic                       tick,
    output logic                       clk_hz,
    output logic [$clog2(NUM_LVL)-1:0] lvl
);

    localparam int LW = $clog2(NUM_LVL);
    localparam int CW = $clog2(BASE_DIV);
    localparam int DW = $clog2(DEB_CYC + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
    localparam logic [LW-1:0] LVL_MAX  = LW'(NUM_LVL - 1);

    logic [1:0]    btn_raw;
    logic [1:0]    press;
    logic [LW-1:0] lvl_reg;
    logic [LW-1:0] lvl_next;
    logic          lvl_chg;
    logic [CW-1:0] cnt_reg;
    logic          tick_reg;
    logic          clk_hz_reg;
    logic [CW-1:0] term_m1 [NUM_LVL];

    // Index 0 is the up button, index 1 the down button.
    assign btn_raw = {btn_dn, btn_up};

    for (genvar gi = 0; gi < 2; gi++) begin : g_deb
        logic          s1_reg;
        logic          s2_reg;
        logic          stable_reg;
        logic [DW-1:0] deb_cnt_reg;

        always_ff @(posedge CLK or negedge rs) begin
            if (!rs) begin
                s1_reg      <= 1'b1;
                s2_reg      <= 1'b1;
                stable_reg  <= 1'b1;
                deb_cnt_reg <= '0;
            end else begin
                s1_reg <= btn_raw[gi];
                s2_reg <= s1_reg;
                if (s2_reg == stable_reg) begin
                    deb_cnt_reg <= '0;
                end else if (deb_cnt_reg == DEB_LAST) begin
                    stable_reg  <= s2_reg;
                    deb_cnt_reg <= '0;
                end else begin
                    deb_cnt_reg <= deb_cnt_reg + 1'b1;
                end
            end
        end

        // Press fires in the same cycle the debounced state falls to 0.
        assign press[gi] = stable_reg & ~s2_reg & (deb_cnt_reg == DEB_LAST);
    end

    for (genvar gi = 0; gi < NUM_LVL; gi++) begin : g_term
        assign term_m1[gi] = CW'((BASE_DIV >> gi) - 1);
    end

    always_comb begin
        lvl_next = lvl_reg;
        if (press[0] && !press[1] && lvl_reg != LVL_MAX) begin
            lvl_next = lvl_reg + 1'b1;
        end else if (press[1] && !press[0] && lvl_reg != '0) begin
            lvl_next = lvl_reg - 1'b1;
        end
    end

    // Saturated or cancelling presses leave lvl_next == lvl_reg, so the count runs on.
    assign lvl_chg = (lvl_next != lvl_reg);

    always_ff @(posedge CLK or negedge rs) begin
        if (!rs) begin
            lvl_reg    <= '0;
            cnt_reg    <= '0;
            tick_reg   <= 1'b0;
            clk_hz_reg <= 1'b0;
        end else begin
            lvl_reg <= lvl_next;
            if (lvl_chg) begin
                cnt_reg  <= '0;
                tick_reg <= 1'b0;
            end else if (cnt_reg == term_m1[lvl_reg]) begin
                cnt_reg    <= '0;
                tick_reg   <= 1'b1;
                clk_hz_reg <= ~clk_hz_reg;
            end else begin
                cnt_reg  <= cnt_reg + 1'b1;
                tick_reg <= 1'b0;
            end
        end
    end

    assign tick   = tick_reg;
    assign clk_hz = clk_hz_reg;
    assign lvl    = lvl_reg;

endmodule

// File: tb/tb_chia_xung_tocdo.sv
// Directed bench for chia_xung_tocdo with BASE_DIV=16, DEB_CYC=4, NUM_LVL=4.
module tb_chia_xung_tocdo;

    logic       CLK = 1'b0;
    logic       rs = 1'b0;
    logic       btn_up = 1'b1;
    logic       btn_dn = 1'b1;
    logic       tick;
    logic       clk_hz;
    logic [1:0] lvl;

    int checks = 0;
    int errors = 0;

    chia_xung_tocdo #(
        .BASE_DIV (16),
        .DEB_CYC  (4),
        .NUM_LVL  (4)
    ) dut (
        .CLK    (CLK),
        .rs     (rs),
        .btn_up (btn_up),
        .btn_dn (btn_dn),
        .tick   (tick),
        .clk_hz (clk_hz),
        .lvl    (lvl)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Leaves rs rising at a falling edge; the next rising edge is cycle 1.
    task automatic do_reset();
        rs = 1'b0;
        btn_up = 1'b1;
        btn_dn = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        rs = 1'b1;
    endtask

    task automatic press(input bit dn);
        if (dn) btn_dn = 1'b0;
        else    btn_up = 1'b0;
        repeat (8) step();
        btn_up = 1'b1;
        btn_dn = 1'b1;
        repeat (8) step();
    endtask

    task automatic test_reset();
        @(negedge CLK);
        checks++;
        if (tick !== 1'b0 || clk_hz !== 1'b0 || lvl !== 2'd0) begin
            errors++;
            $display("FAIL reset tick=%b clk_hz=%b lvl=%0d required 0 0 0", tick, clk_hz, lvl);
        end
        $display("reset: tick=%b clk_hz=%b lvl=%0d", tick, clk_hz, lvl);
    endtask

    task automatic test_divider();
        bit exp_tick, exp_hz;
        do_reset();
        for (int n = 1; n <= 40; n++) begin
            step();
            exp_tick = (n % 16 == 0);
            exp_hz = ((n / 16) % 2) == 1;
            checks++;
            if (tick !== exp_tick || clk_hz !== exp_hz || lvl !== 2'd0) begin
                errors++;
                $display("FAIL divider cyc=%0d tick=%b clk_hz=%b lvl=%0d required %b %b 0",
                         n, tick, clk_hz, lvl, exp_tick, exp_hz);
            end
        end
        $display("divider: lvl0 ticks at 16/32 checked");
    endtask

    task automatic test_up_hold();
        bit exp_tick, exp_hz;
        logic [1:0] exp_lvl;
        do_reset();
        btn_up = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (n == 10) btn_up = 1'b1;
            exp_lvl = (n >= 6) ? 2'd1 : 2'd0;
            exp_tick = (n >= 14) && ((n - 6) % 8 == 0);
            exp_hz = (n >= 14) ? (((n - 6) / 8) % 2 == 1) : 1'b0;
            checks++;
            if (tick !== exp_tick || clk_hz !== exp_hz || lvl !== exp_lvl) begin
                errors++;
                $display("FAIL up_hold cyc=%0d tick=%b clk_hz=%b lvl=%0d required %b %b %0d",
                         n, tick, clk_hz, lvl, exp_tick, exp_hz, exp_lvl);
            end
        end
        $display("up_hold: single step to lvl1 at cycle 6, period 8 checked");
    endtask

    task automatic test_glitch();
        bit exp_tick;
        do_reset();
        btn_up = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (n == 3) btn_up = 1'b1;
            exp_tick = (n % 16 == 0);
            checks++;
            if (tick !== exp_tick || lvl !== 2'd0) begin
                errors++;
                $display("FAIL glitch cyc=%0d tick=%b lvl=%0d required %b 0", n, tick, lvl, exp_tick);
            end
        end
        $display("glitch: 3-cycle low rejected");
    endtask

    task automatic test_saturate();
        logic [1:0] exp_up [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic [1:0] exp_dn [4] = '{2'd2, 2'd1, 2'd0, 2'd0};
        bit found;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            press(1'b0);
            checks++;
            if (lvl !== exp_up[i]) begin
                errors++;
                $display("FAIL up_press%0d lvl=%0d required %0d", i, lvl, exp_up[i]);
            end
            $display("up press %0d: lvl=%0d", i, lvl);
        end
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            if (tick === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL lvl3_tick_seen tick=0 required 1 within 10 cycles");
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (tick !== (k % 2 == 0)) begin
                errors++;
                $display("FAIL lvl3_period k=%0d tick=%b required %b", k, tick, (k % 2 == 0));
            end
        end
        $display("lvl3: tick every 2 cycles checked");
        for (int i = 0; i < 4; i++) begin
            press(1'b1);
            checks++;
            if (lvl !== exp_dn[i]) begin
                errors++;
                $display("FAIL dn_press%0d lvl=%0d required %0d", i, lvl, exp_dn[i]);
            end
            $display("dn press %0d: lvl=%0d", i, lvl);
        end
    endtask

    task automatic test_both();
        bit exp_tick;
        do_reset();
        btn_up = 1'b0;
        btn_dn = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (n == 10) begin
                btn_up = 1'b1;
                btn_dn = 1'b1;
            end
            exp_tick = (n % 16 == 0);
            checks++;
            if (tick !== exp_tick || lvl !== 2'd0) begin
                errors++;
                $display("FAIL both cyc=%0d tick=%b lvl=%0d required %b 0", n, tick, lvl, exp_tick);
            end
        end
        $display("both: simultaneous presses cancel, count undisturbed");
    endtask

    task automatic test_async_reset();
        bit found;
        do_reset();
        press(1'b0);
        press(1'b0);
        checks++;
        if (lvl !== 2'd2) begin
            errors++;
            $display("FAIL async_pre lvl=%0d required 2", lvl);
        end
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (tick === 1'b1 && clk_hz === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL async_setup tick&clk_hz=0 required 1 within 20 cycles");
        end
        #2 rs = 1'b0;
        #1;
        checks++;
        if (tick !== 1'b0 || clk_hz !== 1'b0 || lvl !== 2'd0) begin
            errors++;
            $display("FAIL async_reset tick=%b clk_hz=%b lvl=%0d required 0 0 0", tick, clk_hz, lvl);
        end
        $display("async reset: tick=%b clk_hz=%b lvl=%0d", tick, clk_hz, lvl);
        @(negedge CLK);
        rs = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            step();
            checks++;
            if (tick !== (n == 16) || lvl !== 2'd0) begin
                errors++;
                $display("FAIL post_reset cyc=%0d tick=%b lvl=%0d required %b 0", n, tick, lvl, (n == 16));
            end
        end
    endtask

    initial begin
        test_reset();
        test_divider();
        test_up_hold();
        test_glitch();
        test_saturate();
        test_both();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
